l1i_flush_ctrl: RTL and testbench

//  Sequences whole-cache invalidation of the L1 I-cache directory (fence.i, power-up) and arbitrates
//  the single directory port between the IFU and the internal flush walker. Sits between the IFU's

---
 rtl/l1i_flush_ctrl.sv | 93 +++++++++
 tb/tb_l1i_flush_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/l1i_flush_ctrl.sv
// L1 I-cache directory flush sequencer: walks every set clearing the valid bit,
// and shares the single directory port between the IFU and the walker.
module l1i_flush_ctrl #(
    parameter int INDEX_WIDTH    = 6,
    parameter int TAG_WIDTH      = 20,
    parameter bit FLUSH_ON_RESET = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_valid,
    output logic                   flush_ready,
    output logic                   flush_done,
    input  logic                   ifu_busy,
    output logic                   ifu_stall,
    input  logic [INDEX_WIDTH-1:0] ifu_dir_index,
    input  logic                   ifu_dir_write,
    input  logic [TAG_WIDTH-1:0]   ifu_dir_next_tag,
    input  logic                   ifu_dir_next_v,
    output logic [TAG_WIDTH-1:0]   ifu_dir_cur_tag,
    output logic                   ifu_dir_cur_v,
    output logic [INDEX_WIDTH-1:0] dir_index,
    output logic                   dir_write,
    output logic [TAG_WIDTH-1:0]   dir_next_tag,
    output logic                   dir_next_v,
    input  logic [TAG_WIDTH-1:0]   dir_cur_tag,
    input  logic                   dir_cur_v
);

    typedef enum logic [1:0] {IDLE, DRAIN, WALK, DONE} state_t;

    // Power-up directory contents are garbage, so optionally start straight in WALK.
    localparam state_t RESET_STATE = FLUSH_ON_RESET ? WALK : IDLE;
    localparam logic [INDEX_WIDTH-1:0] LAST_SET = '1;

    state_t                 state, state_next;
    logic [INDEX_WIDTH-1:0] cnt, cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RESET_STATE;
            cnt        <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            flush_done <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (flush_valid) state_next = DRAIN;
            end
            DRAIN: begin
                if (!ifu_busy) begin
                    cnt_next   = '0;
                    state_next = WALK;
                end
            end
            WALK: begin
                // Counter wraps back to zero after the last set; that value is never used.
                cnt_next = cnt + INDEX_WIDTH'(1);
                if (cnt == LAST_SET) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        flush_ready  = (state == IDLE);
        ifu_stall    = (state != IDLE);
        dir_index    = ifu_dir_index;
        dir_write    = ifu_dir_write;
        dir_next_tag = ifu_dir_next_tag;
        dir_next_v   = ifu_dir_next_v;
        if (state == WALK) begin
            dir_index    = cnt;
            dir_write    = 1'b1;
            dir_next_tag = '0;
            dir_next_v   = 1'b0;
        end
    end

    assign ifu_dir_cur_tag = dir_cur_tag;
    assign ifu_dir_cur_v   = dir_cur_v;

endmodule

// File: tb/tb_l1i_flush_ctrl.sv
// Directed bench for l1i_flush_ctrl: power-up walk, pass-through, flush latency,
// drain of an outstanding refill, held request and reset mid-walk.
module tb_l1i_flush_ctrl;

    localparam int IW = 6;
    localparam int TW = 20;
    localparam int NUM_SETS = 1 << IW;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_valid;
    logic          flush_ready;
    logic          flush_done;
    logic          ifu_busy;
    logic          ifu_stall;
    logic [IW-1:0] ifu_dir_index;
    logic          ifu_dir_write;
    logic [TW-1:0] ifu_dir_next_tag;
    logic          ifu_dir_next_v;
    logic [TW-1:0] ifu_dir_cur_tag;
    logic          ifu_dir_cur_v;
    logic [IW-1:0] dir_index;
    logic          dir_write;
    logic [TW-1:0] dir_next_tag;
    logic          dir_next_v;
    logic [TW-1:0] dir_cur_tag;
    logic          dir_cur_v;

    int n_chk  = 0;
    int n_pass = 0;

    l1i_flush_ctrl #(
        .INDEX_WIDTH(IW),
        .TAG_WIDTH(TW),
        .FLUSH_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush_valid(flush_valid),
        .flush_ready(flush_ready),
        .flush_done(flush_done),
        .ifu_busy(ifu_busy),
        .ifu_stall(ifu_stall),
        .ifu_dir_index(ifu_dir_index),
        .ifu_dir_write(ifu_dir_write),
        .ifu_dir_next_tag(ifu_dir_next_tag),
        .ifu_dir_next_v(ifu_dir_next_v),
        .ifu_dir_cur_tag(ifu_dir_cur_tag),
        .ifu_dir_cur_v(ifu_dir_cur_v),
        .dir_index(dir_index),
        .dir_write(dir_write),
        .dir_next_tag(dir_next_tag),
        .dir_next_v(dir_next_v),
        .dir_cur_tag(dir_cur_tag),
        .dir_cur_v(dir_cur_v)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Current cycle must be the first WALK cycle; leaves the bench in the DONE cycle.
    task automatic run_walk(input string tag);
        for (int i = 0; i < NUM_SETS; i++) begin
            #1;
            check({tag, "_wr"}, {dir_write, dir_next_v, dir_next_tag, 2'b00, dir_index},
                  {1'b1, 1'b0, 20'h0, 2'b00, 6'(i)});
            check({tag, "_nodone"}, {31'h0, flush_done}, 32'h0);
            next_cyc();
        end
        #1;
        check({tag, "_done"}, {30'h0, flush_done, dir_write}, {30'h0, 1'b1, 1'b0});
        check({tag, "_done_stall"}, {30'h0, ifu_stall, flush_ready}, {30'h0, 1'b1, 1'b0});
    endtask

    initial begin
        rst = 1'b1;
        flush_valid = 1'b0;
        ifu_busy = 1'b0;
        ifu_dir_index = '0;
        ifu_dir_write = 1'b0;
        ifu_dir_next_tag = '0;
        ifu_dir_next_v = 1'b0;
        dir_cur_tag = '0;
        dir_cur_v = 1'b0;

        // 1: power-up walk
        #2;
        check("rst_outs", {28'h0, flush_done, flush_ready, ifu_stall, dir_write}, 32'h3);
        check("rst_idx", {26'h0, dir_index}, 32'h0);
        next_cyc();
        next_cyc();
        rst = 1'b0;
        run_walk("pwr");
        next_cyc();
        #1;
        check("pwr_idle", {29'h0, flush_ready, ifu_stall, flush_done}, 32'h4);

        // 2: pass-through in IDLE
        ifu_dir_write = 1'b1;
        ifu_dir_index = 6'd5;
        ifu_dir_next_tag = 20'hABCDE;
        ifu_dir_next_v = 1'b1;
        dir_cur_tag = 20'h12345;
        dir_cur_v = 1'b1;
        #1;
        check("pt_wr", {24'h0, dir_write, dir_next_v, dir_index}, {24'h0, 1'b1, 1'b1, 6'd5});
        check("pt_tag", {12'h0, dir_next_tag}, 32'hABCDE);
        check("pt_rd", {11'h0, ifu_dir_cur_v, ifu_dir_cur_tag}, {11'h0, 1'b1, 20'h12345});
        dir_cur_v = 1'b0;
        #1;
        check("pt_rd_v0", {31'h0, ifu_dir_cur_v}, 32'h0);
        ifu_dir_write = 1'b0;
        ifu_dir_next_v = 1'b0;
        ifu_dir_next_tag = '0;
        ifu_dir_index = '0;

        // 3: flush with idle IFU
        next_cyc();
        flush_valid = 1'b1;
        #1;
        check("f3_ready_T", {31'h0, flush_ready}, 32'h1);
        next_cyc();
        flush_valid = 1'b0;
        #1;
        check("f3_drain", {29'h0, ifu_stall, flush_ready, dir_write}, 32'h4);
        next_cyc();
        run_walk("f3");
        next_cyc();
        #1;
        check("f3_idle", {29'h0, flush_ready, ifu_stall, flush_done}, 32'h4);

        // 4: flush while the IFU finishes a refill
        flush_valid = 1'b1;
        ifu_busy = 1'b1;
        for (int c = 1; c < 10; c++) begin
            next_cyc();
            flush_valid = 1'b0;
            if (c == 9) begin
                ifu_dir_write = 1'b1;
                ifu_dir_index = 6'd9;
                ifu_dir_next_tag = 20'h00009;
                ifu_dir_next_v = 1'b1;
                #1;
                check("f4_refill", {24'h0, dir_write, dir_next_v, dir_index}, {24'h0, 1'b1, 1'b1, 6'd9});
                check("f4_refill_tag", {12'h0, dir_next_tag}, 32'h00009);
            end else begin
                #1;
                check("f4_drain", {30'h0, ifu_stall, dir_write}, 32'h2);
            end
        end
        next_cyc();
        ifu_busy = 1'b0;
        ifu_dir_write = 1'b0;
        ifu_dir_next_v = 1'b0;
        ifu_dir_next_tag = '0;
        ifu_dir_index = '0;
        #1;
        check("f4_last_drain", {30'h0, ifu_stall, dir_write}, 32'h2);
        next_cyc();
        run_walk("f4");
        next_cyc();
        #1;
        check("f4_idle", {31'h0, flush_ready}, 32'h1);

        // 5: request held through DONE
        flush_valid = 1'b1;
        next_cyc();
        #1;
        check("f5_drain", {31'h0, flush_ready}, 32'h0);
        next_cyc();
        run_walk("f5");
        next_cyc();
        #1;
        check("f5_reaccept", {30'h0, flush_ready, flush_done}, 32'h2);
        next_cyc();
        flush_valid = 1'b0;
        #1;
        check("f5_drain2", {30'h0, ifu_stall, dir_write}, 32'h2);
        next_cyc();
        run_walk("f5b");
        next_cyc();
        #1;
        check("f5_idle", {31'h0, flush_ready}, 32'h1);

        // 6: reset at walk index 30
        flush_valid = 1'b1;
        next_cyc();
        flush_valid = 1'b0;
        for (int c = 0; c < 31; c++) next_cyc();
        #1;
        check("f6_at30", {25'h0, dir_write, dir_index}, {25'h0, 1'b1, 6'd30});
        rst = 1'b1;
        #1;
        check("f6_rst_idx", {25'h0, dir_write, dir_index}, {25'h0, 1'b1, 6'd0});
        check("f6_rst_ctl", {29'h0, flush_done, flush_ready, ifu_stall}, 32'h1);
        next_cyc();
        rst = 1'b0;
        run_walk("f6");
        next_cyc();
        #1;
        check("f6_idle", {30'h0, flush_ready, flush_done}, 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
